z80_mmu_paged: RTL and testbench

//  Next-generation Z80 memory-management unit. Maps the CPU address space onto a

---
 rtl/z80_mmu_pkg.sv | 22 ++
 rtl/z80_io_strobe.sv | 45 ++++
 rtl/z80_mmu_paged.sv | 186 ++++++++++++++++++
 tb/tb_z80_mmu_paged.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_mmu_pkg.sv
// Shared constants and types for the paged Z80 MMU.
package z80_mmu_pkg;

    localparam logic [3:0] OFF_CLKDIV = 4'h0;
    localparam logic [3:0] OFF_BEEP   = 4'h1;
    localparam logic [3:0] OFF_KEY    = 4'h2;
    localparam logic [7:0] KEY1_VAL   = 8'hA5;
    localparam logic [7:0] KEY2_VAL   = 8'h5A;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        KEY1   = 2'd1,
        OPEN   = 2'd2
    } lock_state_t;

    // Captured I/O write: register offset inside the window plus data byte.
    typedef struct packed {
        logic [3:0] off;
        logic [7:0] data;
    } io_wr_t;

endpackage

// File: rtl/z80_io_strobe.sv
// Brings the asynchronous Z80 I/O write select into the clk domain and
// emits one pulse per bus write, together with the captured offset/data.
module z80_io_strobe
    import z80_mmu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wsel,
    input  logic [3:0] off_in,
    input  logic [7:0] data_in,
    output logic       wr_pulse,
    output io_wr_t     wr_info
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    io_wr_t     cap_q,  cap_d;

    // Shift the synchroniser; latch offset/data as the second stage first goes high.
    always_comb begin
        sync_d = {sync_q[0], wsel};
        prev_d = sync_q[1];
        cap_d  = cap_q;
        if (sync_q[0] && !sync_q[1]) begin
            cap_d = '{off: off_in, data: data_in};
        end
    end

    // Synchroniser, edge-history and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cap_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cap_q  <= cap_d;
        end
    end

    assign wr_pulse = sync_q[1] & ~prev_q;
    assign wr_info  = cap_q;

endmodule

// File: rtl/z80_mmu_paged.sv
// Paged Z80 MMU: page map with key-locked writes, sysclk divider and beeper.
module z80_mmu_paged
    import z80_mmu_pkg::*;
#(
    parameter int unsigned PAGE_BITS = 3,
    parameter int unsigned MAP_W     = 8,
    parameter logic [7:0]  IO_BASE   = 8'hD0,
    parameter int unsigned CLKDIV_W  = 2,
    parameter int unsigned BEEP_PRE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iorq,
    input  logic                 mreq,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [7:0]           a07,
    input  logic [PAGE_BITS-1:0] a_hi,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic [MAP_W-2:0]     pa,
    output logic                 romen,
    output logic                 ramen,
    output logic                 sysclk,
    output logic                 beep
);

    localparam int unsigned NPAGES = 2 ** PAGE_BITS;

    logic                 hit_c, wsel_c, wr_pulse;
    io_wr_t               wr_info;
    logic                 clkdiv_we_c, beep_we_c, key_we_c, page_wr_c, page_we_c;
    logic [PAGE_BITS-1:0] wr_idx_c;
    logic [7:0]           rdata_c;
    logic [MAP_W-1:0]     entry_c;

    lock_state_t          state_q, state_d;
    logic [MAP_W-1:0]     map_q [NPAGES];
    logic [MAP_W-1:0]     map_d [NPAGES];
    logic [CLKDIV_W-1:0]  clkdiv_q, clkdiv_d, cnt_q, cnt_d;
    logic [7:0]           beep_val_q, beep_val_d, per_q, per_d;
    logic [BEEP_PRE-1:0]  pre_q, pre_d;
    logic                 sysclk_q, sysclk_d, beep_q, beep_d;

    // Page entries sit at offsets 8 .. 8+NPAGES-1 of the window.
    function automatic logic is_page(input logic [3:0] off);
        return off[3] && ({1'b0, off[2:0]} < 4'(NPAGES));
    endfunction

    assign hit_c  = (a07[7:4] == IO_BASE[7:4]);
    assign wsel_c = ~iorq & ~wr & hit_c;

    z80_io_strobe u_strobe (
        .clk      (clk),
        .reset    (reset),
        .wsel     (wsel_c),
        .off_in   (a07[3:0]),
        .data_in  (data_in),
        .wr_pulse (wr_pulse),
        .wr_info  (wr_info)
    );

    assign clkdiv_we_c = wr_pulse && (wr_info.off == OFF_CLKDIV);
    assign beep_we_c   = wr_pulse && (wr_info.off == OFF_BEEP);
    assign key_we_c    = wr_pulse && (wr_info.off == OFF_KEY);
    assign page_wr_c   = wr_pulse && is_page(wr_info.off);
    assign wr_idx_c    = wr_info.off[PAGE_BITS-1:0];

    // Lock state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= LOCKED;
        else        state_q <= state_d;
    end

    // Lock next state: only key writes advance or abort the sequence.
    always_comb begin
        state_d = state_q;
        if (key_we_c) begin
            case (state_q)
                LOCKED:  state_d = (wr_info.data == KEY1_VAL) ? KEY1 : LOCKED;
                KEY1:    state_d = (wr_info.data == KEY2_VAL) ? OPEN : LOCKED;
                default: state_d = LOCKED;
            endcase
        end
    end

    // Lock outputs: page writes are honoured only while open.
    always_comb begin
        page_we_c = 1'b0;
        if (state_q == OPEN && page_wr_c) page_we_c = 1'b1;
    end

    // Next state for the register file, sysclk divider and beeper.
    always_comb begin
        for (int i = 0; i < NPAGES; i++) map_d[i] = map_q[i];
        clkdiv_d   = clkdiv_q;
        beep_val_d = beep_val_q;
        cnt_d      = CLKDIV_W'(cnt_q + 1'b1);
        sysclk_d   = sysclk_q;
        pre_d      = pre_q;
        per_d      = per_q;
        beep_d     = beep_q;

        if (page_we_c)   map_d[wr_idx_c] = wr_info.data[MAP_W-1:0];
        if (clkdiv_we_c) clkdiv_d = wr_info.data[CLKDIV_W-1:0];

        // >= so that lowering clkdiv mid-count ends the half-period at once.
        if (cnt_q >= clkdiv_q) begin
            cnt_d    = '0;
            sysclk_d = ~sysclk_q;
        end

        if (beep_we_c) begin
            beep_val_d = wr_info.data;
            pre_d      = '0;
            per_d      = '0;
            if (wr_info.data == 8'h00) beep_d = 1'b0;
        end else if (beep_val_q == 8'h00) begin
            beep_d = 1'b0;
        end else begin
            pre_d = BEEP_PRE'(pre_q + 1'b1);
            if (&pre_q) begin
                if (per_q == beep_val_q - 8'd1) begin
                    per_d  = '0;
                    beep_d = ~beep_q;
                end else begin
                    per_d = per_q + 8'd1;
                end
            end
        end
    end

    // Register file, divider and beeper state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPAGES; i++)
                map_q[i] <= (i == 0) ? '0 : {1'b1, (MAP_W-1)'(i)};
            clkdiv_q   <= CLKDIV_W'(1);
            beep_val_q <= '0;
            cnt_q      <= '0;
            sysclk_q   <= 1'b0;
            pre_q      <= '0;
            per_q      <= '0;
            beep_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NPAGES; i++) map_q[i] <= map_d[i];
            clkdiv_q   <= clkdiv_d;
            beep_val_q <= beep_val_d;
            cnt_q      <= cnt_d;
            sysclk_q   <= sysclk_d;
            pre_q      <= pre_d;
            per_q      <= per_d;
            beep_q     <= beep_d;
        end
    end

    assign sysclk = sysclk_q;
    assign beep   = beep_q;

    // Zero-latency register read-back.
    always_comb begin
        rdata_c = '0;
        if (is_page(a07[3:0])) begin
            rdata_c = 8'(map_q[a07[PAGE_BITS-1:0]]);
        end else begin
            case (a07[3:0])
                OFF_CLKDIV: rdata_c = 8'(clkdiv_q);
                OFF_BEEP:   rdata_c = beep_val_q;
                OFF_KEY:    rdata_c = {6'b0, state_q};
                default:    rdata_c = '0;
            endcase
        end
        data_oe  = ~iorq & ~rd & hit_c;
        data_out = data_oe ? rdata_c : 8'h00;
    end

    // Combinational address translation and chip selects.
    always_comb begin
        entry_c = map_q[a_hi];
        pa      = entry_c[MAP_W-2:0];
        romen   = mreq | entry_c[MAP_W-1];
        ramen   = mreq | ~entry_c[MAP_W-1];
    end

endmodule

// File: tb/tb_z80_mmu_paged.sv
// Randomised self-checking bench for z80_mmu_paged against a behavioural model.
module tb_z80_mmu_paged;

    logic       clk = 1'b0;
    logic       reset;
    logic       iorq, mreq, rd, wr;
    logic [7:0] a07, data_in, data_out;
    logic [2:0] a_hi;
    logic       data_oe;
    logic [6:0] pa;
    logic       romen, ramen, sysclk, beep;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the programmer-visible state.
    logic [7:0] m_map [8];
    int         m_clkdiv;
    int         m_beep;
    int         m_keys;     // 0 = locked, 1 = first key seen, 2 = open

    z80_mmu_paged dut (
        .clk      (clk),
        .reset    (reset),
        .iorq     (iorq),
        .mreq     (mreq),
        .rd       (rd),
        .wr       (wr),
        .a07      (a07),
        .a_hi     (a_hi),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .pa       (pa),
        .romen    (romen),
        .ramen    (ramen),
        .sysclk   (sysclk),
        .beep     (beep)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_map[0] = 8'h00;
        for (int i = 1; i < 8; i++) m_map[i] = 8'h80 + 8'(i);
        m_clkdiv = 1;
        m_beep   = 0;
        m_keys   = 0;
    endfunction

    function automatic void model_write(input logic [7:0] addr, input logic [7:0] d);
        if (addr[7:4] != 4'hD) return;
        if (addr[3]) begin
            if (m_keys == 2) m_map[addr[2:0]] = d;
        end else if (addr[3:0] == 4'h0) begin
            m_clkdiv = int'(d) % 4;
        end else if (addr[3:0] == 4'h1) begin
            m_beep = int'(d);
        end else if (addr[3:0] == 4'h2) begin
            if (m_keys == 0 && d == 8'hA5)      m_keys = 1;
            else if (m_keys == 1 && d == 8'h5A) m_keys = 2;
            else                                m_keys = 0;
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] addr);
        if (addr[7:4] != 4'hD) return 8'h00;
        if (addr[3]) return m_map[addr[2:0]];
        case (addr[3:0])
            4'h0:    return 8'(m_clkdiv);
            4'h1:    return 8'(m_beep);
            4'h2:    return 8'(m_keys);
            default: return 8'h00;
        endcase
    endfunction

    task automatic io_write(input logic [7:0] addr, input logic [7:0] d, input int hold);
        @(negedge clk);
        a07 = addr; data_in = d; iorq = 1'b0; wr = 1'b0;
        repeat (hold) @(negedge clk);
        iorq = 1'b1; wr = 1'b1;
        repeat (4) @(negedge clk);
        model_write(addr, d);
    endtask

    task automatic rd_chk(input logic [7:0] addr);
        logic exp_oe;
        @(negedge clk);
        a07 = addr; iorq = 1'b0; rd = 1'b0;
        #1;
        exp_oe = (addr[7:4] == 4'hD);
        chk_eq($sformatf("oe@%h", addr), 32'(data_oe), 32'(exp_oe));
        chk_eq($sformatf("rd@%h", addr), 32'(data_out), 32'(model_read(addr)));
        iorq = 1'b1; rd = 1'b1;
    endtask

    task automatic xlate_chk(input logic [2:0] hi, input logic mq);
        logic [7:0] e;
        logic       exp_rom, exp_ram;
        @(negedge clk);
        a_hi = hi; mreq = mq;
        #1;
        e = m_map[hi];
        exp_rom = mq ? 1'b1 : (e[7] ? 1'b1 : 1'b0);
        exp_ram = mq ? 1'b1 : (e[7] ? 1'b0 : 1'b1);
        chk_eq($sformatf("pa[%0d]", hi), 32'(pa), 32'(e[6:0]));
        chk_eq($sformatf("romen[%0d]", hi), 32'(romen), 32'(exp_rom));
        chk_eq($sformatf("ramen[%0d]", hi), 32'(ramen), 32'(exp_ram));
        mreq = 1'b1;
    endtask

    // Sync to one toggle of sysclk/beep, then count clk cycles to the next toggle.
    task automatic measure(input string tag, input bit use_beep, input int exp_half, input int bound);
        logic s0;
        int   n;
        @(posedge clk); #1;
        s0 = use_beep ? beep : sysclk;
        n  = 0;
        while ((use_beep ? beep : sysclk) == s0 && n < bound) begin
            @(posedge clk); #1; n++;
        end
        s0 = use_beep ? beep : sysclk;
        n  = 0;
        do begin
            @(posedge clk); #1; n++;
        end while ((use_beep ? beep : sysclk) == s0 && n < bound);
        chk_eq(tag, 32'(n), 32'(exp_half));
    endtask

    task automatic wait_beep(input logic lvl);
        int n = 0;
        while (beep !== lvl && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk_eq("beep_reach_level", 32'(beep), 32'(lvl));
    endtask

    initial begin
        logic       s_prev, exp_bit;
        int         n, op, stuck;
        logic [7:0] addr, d;

        reset = 1'b0; iorq = 1'b1; mreq = 1'b1; rd = 1'b1; wr = 1'b1;
        a07 = 8'h00; data_in = 8'h00; a_hi = 3'd0;
        model_reset();
        #1;
        chk_eq("rst_sysclk", 32'(sysclk), 32'd0);
        chk_eq("rst_beep", 32'(beep), 32'd0);
        chk_eq("rst_data_oe", 32'(data_oe), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset map and translation.
        rd_chk(8'hD8);
        rd_chk(8'hD9);
        rd_chk(8'hD0);
        rd_chk(8'hD2);
        xlate_chk(3'd0, 1'b0);
        xlate_chk(3'd2, 1'b0);
        xlate_chk(3'd2, 1'b1);
        measure("sysclk_half_rst", 1'b0, 2, 40);

        // Locked page write is dropped; unlock, write, relock.
        io_write(8'hD9, 8'h8F, 2);
        rd_chk(8'hD9);
        io_write(8'hD2, 8'hA5, 2);
        io_write(8'hD2, 8'h5A, 2);
        rd_chk(8'hD2);
        io_write(8'hD9, 8'h8F, 2);
        rd_chk(8'hD9);
        xlate_chk(3'd1, 1'b0);
        chk_eq("pa_a2000_const", 32'(pa), 32'h0F);
        io_write(8'hD2, 8'h00, 2);
        rd_chk(8'hD2);

        // Broken key sequence keeps the map locked.
        io_write(8'hD2, 8'hA5, 2);
        io_write(8'hD2, 8'h11, 2);
        io_write(8'hD2, 8'h5A, 2);
        rd_chk(8'hD2);
        io_write(8'hDA, 8'h33, 2);
        rd_chk(8'hDA);

        // Randomised register traffic.
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 5);
            d  = 8'($urandom);
            case (op)
                0: begin
                    addr = 8'hD8 + 8'($urandom_range(0, 7));
                    io_write(addr, d, $urandom_range(2, 6));
                    rd_chk(addr);
                end
                1: begin
                    n = $urandom_range(0, 2);
                    d = (n == 0) ? 8'hA5 : (n == 1) ? 8'h5A : d;
                    io_write(8'hD2, d, $urandom_range(2, 6));
                    rd_chk(8'hD2);
                end
                2: begin
                    io_write(8'hD2, 8'hA5, 2);
                    io_write(8'hD2, 8'h5A, 2);
                    addr = 8'hD8 + 8'($urandom_range(0, 7));
                    io_write(addr, d, 3);
                    rd_chk(addr);
                end
                3: begin
                    addr = 8'($urandom_range(8'hC0, 8'hEF));
                    io_write(addr, d, $urandom_range(2, 6));
                    rd_chk(addr);
                end
                4: rd_chk(8'($urandom_range(8'hC0, 8'hEF)));
                default: xlate_chk(3'($urandom), 1'($urandom));
            endcase
        end

        // sysclk divider.
        io_write(8'hD0, 8'h00, 2);
        measure("sysclk_half_div0", 1'b0, 1, 40);
        measure("sysclk_half_div0_b", 1'b0, 1, 40);
        io_write(8'hD0, 8'h03, 2);
        measure("sysclk_half_div3", 1'b0, 4, 40);
        measure("sysclk_half_div3_b", 1'b0, 4, 40);
        rd_chk(8'hD0);

        // Drop clkdiv 3 -> 0 two counts into a half-period.
        @(posedge clk); #1;
        s_prev = sysclk; n = 0;
        while (sysclk == s_prev && n < 40) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        a07 = 8'hD0; data_in = 8'h00; iorq = 1'b0; wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_prev = sysclk;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            exp_bit = ~s_prev;
            chk_eq("sysclk_fast_edge", 32'(sysclk), 32'(exp_bit));
            s_prev = sysclk;
        end
        @(negedge clk);
        iorq = 1'b1; wr = 1'b1;
        repeat (4) @(negedge clk);
        model_write(8'hD0, 8'h00);
        measure("sysclk_half_div0_c", 1'b0, 1, 40);

        // Beeper.
        io_write(8'hD1, 8'h02, 2);
        rd_chk(8'hD1);
        measure("beep_half_n2", 1'b1, 512, 2000);
        measure("beep_half_n2_b", 1'b1, 512, 2000);
        io_write(8'hD1, 8'h01, 2);
        measure("beep_half_n1", 1'b1, 256, 2000);
        wait_beep(1'b1);
        io_write(8'hD1, 8'h03, 2);
        chk_eq("beep_keeps_level", 32'(beep), 32'd1);
        measure("beep_half_n3", 1'b1, 768, 2000);
        wait_beep(1'b1);
        io_write(8'hD1, 8'h00, 2);
        chk_eq("beep_stop", 32'(beep), 32'd0);
        stuck = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (beep !== 1'b0) stuck++;
        end
        chk_eq("beep_stays_low", 32'(stuck), 32'd0);
        rd_chk(8'hD1);

        // Long /WR acts once: a doubled A5 would fall back to LOCKED.
        io_write(8'hD2, 8'h00, 2);
        io_write(8'hD2, 8'hA5, 20);
        rd_chk(8'hD2);

        // Reset in the middle of beeping with the map open.
        io_write(8'hD2, 8'h5A, 2);
        io_write(8'hD9, 8'h42, 2);
        rd_chk(8'hD9);
        io_write(8'hD1, 8'h01, 2);
        wait_beep(1'b1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_eq("mid_rst_sysclk", 32'(sysclk), 32'd0);
        chk_eq("mid_rst_beep", 32'(beep), 32'd0);
        chk_eq("mid_rst_data_oe", 32'(data_oe), 32'd0);
        xlate_chk(3'd1, 1'b0);
        chk_eq("mid_rst_pa1_const", 32'(pa), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd_chk(8'hD2);
        rd_chk(8'hD0);
        rd_chk(8'hD1);
        rd_chk(8'hD9);
        rd_chk(8'hD8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
